// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Receive-side command decoder. Consumes the byte stream from
//               the AVR interface and decodes 4-byte frames
//               (SYNC_BYTE, ADDR, DATA, CSUM) into the register file that
//               drives the signal generator.
//               Optional ack transmitter: define UART_CMD_DECODER_ACK_EN.
// Ports       : clk          - system clock (50 MHz)
//               rst          - asynchronous active-high reset
//               rx_data      - received byte
//               new_rx_data  - one-cycle strobe, rx_data valid
//               tx_busy      - AVR transmitter busy
//               tx_data      - ack byte out
//               new_tx_data  - one-cycle strobe, tx_data valid
//               wave_sel     - waveform select
//               amplitude    - output amplitude scale
//               freq_step    - phase increment
//               frame_ok     - pulse, valid frame committed
//               frame_err    - pulse, frame rejected or timed out
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         CTR_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    output logic [1:0]  wave_sel,
    output logic [7:0]  amplitude,
    output logic [15:0] freq_step,
    output logic        frame_ok,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GET_ADDR = 2'd1,
        S_GET_DATA = 2'd2,
        S_GET_CSUM = 2'd3
    } state_t;

    // Timeout fires on the edge that would take the idle count to
    // TIMEOUT_CYCLES, i.e. while the counter holds TIMEOUT_CYCLES-1.
    localparam logic [CTR_W-1:0] c_CNT_LAST = CTR_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CTR_W-1:0] r_cnt;
    logic [7:0]       r_addr;
    logic [7:0]       r_data;
    logic [7:0]       r_freq_lo;
    logic [1:0]       r_wave_sel;
    logic [7:0]       r_amplitude;
    logic [15:0]      r_freq_step;
    logic             r_frame_ok;
    logic             r_frame_err;

    logic             w_commit_ok;
    logic             w_commit_err;
    logic             w_timeout;
    logic [7:0]       w_sum;

    assign w_sum = r_addr + r_data;

    // Next-state and commit decisions
    always_comb begin
        w_state_next = r_state;
        w_commit_ok  = 1'b0;
        w_commit_err = 1'b0;
        // A byte in the expiry cycle takes precedence over the timeout.
        w_timeout    = (r_state != S_IDLE) && !new_rx_data && (r_cnt == c_CNT_LAST);

        case (r_state)
            S_IDLE: begin
                if (new_rx_data && (rx_data == SYNC_BYTE)) begin
                    w_state_next = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (new_rx_data) begin
                    w_state_next = S_GET_DATA;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_commit_err = 1'b1;
                end
            end
            S_GET_DATA: begin
                if (new_rx_data) begin
                    w_state_next = S_GET_CSUM;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_commit_err = 1'b1;
                end
            end
            S_GET_CSUM: begin
                if (new_rx_data) begin
                    w_state_next = S_IDLE;
                    if ((w_sum == rx_data) && (r_addr <= 8'd3)) begin
                        w_commit_ok = 1'b1;
                    end else begin
                        w_commit_err = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_commit_err = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, inter-byte counter and frame field capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= 8'd0;
            r_data  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next == S_IDLE) || new_rx_data) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_GET_ADDR) && new_rx_data) begin
                r_addr <= rx_data;
            end
            if ((r_state == S_GET_DATA) && new_rx_data) begin
                r_data <= rx_data;
            end
        end
    end

    // Register file and result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wave_sel  <= 2'd0;
            r_amplitude <= 8'hFF;
            r_freq_step <= 16'd1;
            r_freq_lo   <= 8'd0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_ok  <= w_commit_ok;
            r_frame_err <= w_commit_err;
            if (w_commit_ok) begin
                case (r_addr[1:0])
                    2'd0:    r_wave_sel  <= r_data[1:0];
                    2'd1:    r_amplitude <= r_data;
                    2'd2:    r_freq_lo   <= r_data;
                    // High byte plus staged low byte land together so the
                    // generator never sees a half-updated step.
                    default: r_freq_step <= {r_data, r_freq_lo};
                endcase
            end
        end
    end

    assign wave_sel  = r_wave_sel;
    assign amplitude = r_amplitude;
    assign freq_step = r_freq_step;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;

`ifdef UART_CMD_DECODER_ACK_EN
    localparam logic [7:0] c_ACK_OK  = 8'h06;
    localparam logic [7:0] c_ACK_ERR = 8'h15;

    logic       r_ack_pend;
    logic [7:0] r_ack_code;
    logic [7:0] r_tx_data;
    logic       r_new_tx_data;

    // Single pending slot; a fresh result written on the same edge as a
    // send overrides the clear, so the newest result is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_pend    <= 1'b0;
            r_ack_code    <= 8'd0;
            r_tx_data     <= 8'd0;
            r_new_tx_data <= 1'b0;
        end else begin
            r_new_tx_data <= 1'b0;
            if (r_ack_pend && !tx_busy) begin
                r_tx_data     <= r_ack_code;
                r_new_tx_data <= 1'b1;
                r_ack_pend    <= 1'b0;
            end
            if (w_commit_ok || w_commit_err) begin
                r_ack_pend <= 1'b1;
                r_ack_code <= w_commit_ok ? c_ACK_OK : c_ACK_ERR;
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign new_tx_data = r_new_tx_data;
`else
    logic w_unused_tx_busy;
    assign w_unused_tx_busy = tx_busy;
    assign tx_data          = 8'd0;
    assign new_tx_data      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Scoreboard bench for uart_cmd_decoder. Stimulus pushes the
//               expected frame result (and ack byte when
//               UART_CMD_DECODER_ACK_EN is defined) into queues; a monitor
//               pops and compares whenever the DUT pulses an output.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cmd_decoder;

    localparam int c_TO = 50000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic [1:0]  wave_sel;
    logic [7:0]  amplitude;
    logic [15:0] freq_step;
    logic        frame_ok;
    logic        frame_err;

    uart_cmd_decoder #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (c_TO),
        .CTR_W          (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .wave_sel    (wave_sel),
        .amplitude   (amplitude),
        .freq_step   (freq_step),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit          ok;
        logic [1:0]  wave;
        logic [7:0]  amp;
        logic [15:0] freq;
        int          due;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        int         due;
    } ack_t;

    exp_t fq[$];
    ack_t aq[$];
    exp_t m_e;
    ack_t m_a;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic busy_seen = 1'b0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        busy_seen <= tx_busy;
    end

    // Monitor: compare every DUT output event against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_ok || frame_err) begin
                n_vec++;
                if (frame_ok && frame_err) begin
                    n_err++;
                    $display("FAIL pulse_excl: frame_ok=%0b frame_err=%0b both high at cycle %0d", frame_ok, frame_err, cyc);
                end else if (fq.size() == 0) begin
                    n_err++;
                    $display("FAIL frame_unexpected: ok=%0b err=%0b at cycle %0d, expected no pulse", frame_ok, frame_err, cyc);
                end else begin
                    m_e = fq.pop_front();
                    if ((frame_ok != m_e.ok) || (wave_sel != m_e.wave) || (amplitude != m_e.amp) ||
                        (freq_step != m_e.freq) || (cyc != m_e.due)) begin
                        n_err++;
                        $display("FAIL frame_result: got ok=%0b wave=%0h amp=%0h freq=%0h cyc=%0d, expected ok=%0b wave=%0h amp=%0h freq=%0h cyc=%0d",
                                 frame_ok, wave_sel, amplitude, freq_step, cyc,
                                 m_e.ok, m_e.wave, m_e.amp, m_e.freq, m_e.due);
                    end
                end
            end
`ifdef UART_CMD_DECODER_ACK_EN
            if (new_tx_data) begin
                n_vec++;
                if (aq.size() == 0) begin
                    n_err++;
                    $display("FAIL ack_unexpected: tx_data=%0h at cycle %0d, expected no ack", tx_data, cyc);
                end else begin
                    m_a = aq.pop_front();
                    if ((tx_data != m_a.code) || (cyc != m_a.due) || busy_seen) begin
                        n_err++;
                        $display("FAIL ack_byte: got code=%0h cyc=%0d busy_before=%0b, expected code=%0h cyc=%0d busy_before=0",
                                 tx_data, cyc, busy_seen, m_a.code, m_a.due);
                    end
                end
            end
`else
            if (new_tx_data || (tx_data != 8'd0)) begin
                n_vec++;
                n_err++;
                $display("FAIL ack_disabled: new_tx_data=%0b tx_data=%0h, expected 0/0", new_tx_data, tx_data);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge; the byte is sampled by the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic expect_frame(input bit ok, input logic [1:0] w, input logic [7:0] a,
                                input logic [15:0] f, input int due, input int ack_due);
        exp_t e;
        ack_t k;
        e.ok = ok; e.wave = w; e.amp = a; e.freq = f; e.due = due;
        fq.push_back(e);
        k.code = ok ? 8'h06 : 8'h15;
        k.due  = ack_due;
`ifdef UART_CMD_DECODER_ACK_EN
        if (ack_due >= 0) aq.push_back(k);
`endif
    endtask

    // Full 4-byte frame; the result appears the cycle after the CSUM edge,
    // the ack one cycle later (or deferred when push_ack is 0).
    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input bit ok, input logic [1:0] w,
                         input logic [7:0] a, input logic [15:0] f, input bit push_ack);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        expect_frame(ok, w, a, f, cyc + 1, push_ack ? cyc + 2 : -1);
        send_byte(b3);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        rx_data     = 8'd0;
        new_rx_data = 1'b0;
        tx_busy     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_wave_sel",    32'(wave_sel),    32'h0);
        chk("rst_amplitude",   32'(amplitude),   32'hFF);
        chk("rst_freq_step",   32'(freq_step),   32'h1);
        chk("rst_frame_ok",    32'(frame_ok),    32'h0);
        chk("rst_frame_err",   32'(frame_err),   32'h0);
        chk("rst_tx_data",     32'(tx_data),     32'h0);
        chk("rst_new_tx_data", 32'(new_tx_data), 32'h0);

        // amplitude write, then bad checksum leaves it alone
        frame(8'hA5, 8'h01, 8'h80, 8'h81, 1'b1, 2'd0, 8'h80, 16'h0001, 1'b1);
        frame(8'hA5, 8'h01, 8'h80, 8'h00, 1'b0, 2'd0, 8'h80, 16'h0001, 1'b1);
        // shadow low byte, then atomic 16-bit commit
        frame(8'hA5, 8'h02, 8'h34, 8'h36, 1'b1, 2'd0, 8'h80, 16'h0001, 1'b1);
        frame(8'hA5, 8'h03, 8'h12, 8'h15, 1'b1, 2'd0, 8'h80, 16'h1234, 1'b1);
        // good checksum but address out of range
        frame(8'hA5, 8'h04, 8'h00, 8'h04, 1'b0, 2'd0, 8'h80, 16'h1234, 1'b1);

        // timeout: error lands exactly c_TO edges after the last byte
        send_byte(8'hA5);
        send_byte(8'h01);
        expect_frame(1'b0, 2'd0, 8'h80, 16'h1234, cyc + c_TO, cyc + c_TO + 1);
        repeat (c_TO + 5) @(negedge clk);

        frame(8'hA5, 8'h00, 8'h02, 8'h02, 1'b1, 2'd2, 8'h80, 16'h1234, 1'b1);

        // leading non-sync byte is dropped silently
        send_byte(8'h42);
        repeat (2) @(negedge clk);
        frame(8'hA5, 8'h00, 8'h01, 8'h01, 1'b1, 2'd1, 8'h80, 16'h1234, 1'b1);

        // sync value mid-frame is plain data
        frame(8'hA5, 8'h01, 8'hA5, 8'hA6, 1'b1, 2'd1, 8'hA5, 16'h1234, 1'b1);

        // ack held off by a busy transmitter
        tx_busy = 1'b1;
        frame(8'hA5, 8'h01, 8'h40, 8'h41, 1'b1, 2'd1, 8'h40, 16'h1234, 1'b0);
        repeat (96) @(negedge clk);
        expect_frame(1'b1, 2'd0, 8'h00, 16'h0000, -1, cyc + 1);
        void'(fq.pop_back());
        tx_busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_amplitude", 32'(amplitude), 32'h40);

        // reset mid-frame aborts; trailing bytes are ignored
        send_byte(8'hA5);
        send_byte(8'h01);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h80);
        send_byte(8'h81);
        repeat (4) @(negedge clk);
        chk("midrst_amplitude", 32'(amplitude), 32'hFF);
        chk("midrst_freq_step", 32'(freq_step), 32'h1);
        chk("midrst_wave_sel",  32'(wave_sel),  32'h0);

        repeat (5) @(negedge clk);
        chk("frame_queue_empty", 32'(fq.size()), 32'h0);
        chk("ack_queue_empty",   32'(aq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
